valid_ready_out_of_order_completer: RTL and testbench

Out-of-order completion generator. It is the producer for the write side of a reorder buffer.
- Accepts tagged requests (index + data + delay) in order and holds each in a slot.
- Counts each slot's delay down independently.
- Emits completions in the order their delays expire, not the order they arrived.
- Sits between a reservation consumer and the write interface of a reorder buffer; usable as an execution-unit model in benches and as a variable-latency stage in RTL.

---
 rtl/valid_ready_out_of_order_completer_pkg.sv | 15 +
 rtl/valid_ready_out_of_order_completer_first_one.sv | 21 ++
 rtl/valid_ready_out_of_order_completer.sv | 148 ++++++++++++++
 tb/tb_valid_ready_out_of_order_completer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/valid_ready_out_of_order_completer_pkg.sv
// Shared defaults and helpers for the out-of-order completion generator.
// Optional duplicate-index check: VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN.
package valid_ready_out_of_order_completer_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_INDEX_WIDTH = 3;
    localparam int DEF_SLOTS       = 4;
    localparam int DEF_DELAY_WIDTH = 4;

    // Saturating decrement; callers cast to the real counter width.
    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/valid_ready_out_of_order_completer_first_one.sv
// Lowest-set-bit priority encoder; found_o is low when no bit is set.
module valid_ready_out_of_order_completer_first_one #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/valid_ready_out_of_order_completer.sv
// Out-of-order completer: slots count down and release lowest eligible first.
// Optional duplicate-index check: VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN.
module valid_ready_out_of_order_completer
    import valid_ready_out_of_order_completer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int SLOTS       = DEF_SLOTS,
    parameter int DELAY_WIDTH = DEF_DELAY_WIDTH
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   request_valid,
    input  logic [INDEX_WIDTH-1:0] request_index,
    input  logic [WIDTH-1:0]       request_data,
    input  logic [DELAY_WIDTH-1:0] request_delay,
    output logic                   request_ready,
    output logic                   completion_valid,
    output logic [INDEX_WIDTH-1:0] completion_index,
    output logic [WIDTH-1:0]       completion_data,
    input  logic                   completion_ready,
    output logic                   full,
    output logic                   empty
`ifdef VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN
    ,
    output logic                   duplicate_error
`endif
);

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef struct packed {
        logic                   occ;
        logic [INDEX_WIDTH-1:0] idx;
        logic [WIDTH-1:0]       data;
        logic [DELAY_WIDTH-1:0] cnt;
    } slot_t;

    slot_t slots_q [SLOTS];
    slot_t slots_d [SLOTS];

    logic [SLOTS-1:0] occ;
    logic [SLOTS-1:0] elig;
    logic             free_found;
    logic             sel_found;
    logic [SW-1:0]    free_idx;
    logic [SW-1:0]    sel_idx;
    logic             req_fire;
    logic             cmp_fire;

    always_comb begin
        occ  = '0;
        elig = '0;
        for (int i = 0; i < SLOTS; i++) begin
            occ[i]  = slots_q[i].occ;
            elig[i] = slots_q[i].occ && (slots_q[i].cnt == '0);
        end
    end

    valid_ready_out_of_order_completer_first_one #(
        .N (SLOTS)
    ) u_free (
        .req_i   (~occ),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    valid_ready_out_of_order_completer_first_one #(
        .N (SLOTS)
    ) u_sel (
        .req_i   (elig),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );

    assign request_ready    = free_found;
    assign full             = ~free_found;
    assign empty            = ~|occ;
    assign req_fire         = request_valid & free_found;
    assign cmp_fire         = sel_found & completion_ready;
    assign completion_valid = sel_found;

    always_comb begin
        completion_index = '0;
        completion_data  = '0;
        if (sel_found) begin
            completion_index = slots_q[sel_idx].idx;
            completion_data  = slots_q[sel_idx].data;
        end
    end

    // A freed slot and the new request never collide: free slots are unoccupied.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            slots_d[i] = slots_q[i];
            if (slots_q[i].occ && (slots_q[i].cnt != '0)) begin
                slots_d[i].cnt =
                    DELAY_WIDTH'(sat_dec(32'(slots_q[i].cnt)));
            end
            if (cmp_fire && (sel_idx == SW'(i))) begin
                slots_d[i].occ = 1'b0;
            end
            if (req_fire && (free_idx == SW'(i))) begin
                slots_d[i].occ  = 1'b1;
                slots_d[i].idx  = request_index;
                slots_d[i].data = request_data;
                slots_d[i].cnt  = request_delay;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

`ifdef VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN
    logic dup_hit;
    logic dup_q;

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (occ[i] && (slots_q[i].idx == request_index)) begin
                dup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= req_fire & dup_hit;
        end
    end

    assign duplicate_error = dup_q;
`endif

endmodule

// File: tb/tb_valid_ready_out_of_order_completer.sv
// Randomized and directed bench with a slot-level timestamp reference model.
module tb_valid_ready_out_of_order_completer;

    localparam int W  = 8;
    localparam int IW = 3;
    localparam int S  = 4;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          request_valid = 1'b0;
    logic [IW-1:0] request_index = '0;
    logic [W-1:0]  request_data = '0;
    logic [DW-1:0] request_delay = '0;
    logic          request_ready;
    logic          completion_valid;
    logic [IW-1:0] completion_index;
    logic [W-1:0]  completion_data;
    logic          completion_ready = 1'b0;
    logic          full;
    logic          empty;
`ifdef VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN
    logic          duplicate_error;
`endif

    int n_chk = 0;
    int n_pass = 0;

    // Model: occupancy, payload and the absolute cycle a slot becomes eligible.
    bit m_occ [S];
    int m_idx [S];
    int m_dat [S];
    int m_el  [S];
    int now;
    bit m_dup;
    int cq [$];

    valid_ready_out_of_order_completer dut (
        .clock            (clock),
        .resetn           (resetn),
        .request_valid    (request_valid),
        .request_index    (request_index),
        .request_data     (request_data),
        .request_delay    (request_delay),
        .request_ready    (request_ready),
        .completion_valid (completion_valid),
        .completion_index (completion_index),
        .completion_data  (completion_data),
        .completion_ready (completion_ready),
        .full             (full),
        .empty            (empty)
`ifdef VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN
        ,
        .duplicate_error  (duplicate_error)
`endif
    );

    always #5 clock = ~clock;

    function automatic int m_sel();
        for (int i = 0; i < S; i++)
            if (m_occ[i] && now >= m_el[i]) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < S; i++)
            if (!m_occ[i]) return i;
        return -1;
    endfunction

    function automatic bit m_empty();
        for (int i = 0; i < S; i++)
            if (m_occ[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < S; i++) m_occ[i] = 1'b0;
        now = 0;
        m_dup = 1'b0;
        cq.delete();
    endtask

    // One clock: model handshakes from pre-edge state, sample at edge+1.
    task automatic tick();
        int fs;
        int ss;
        bit rf;
        bit cf;
        bit dup;
        fs = m_free();
        ss = m_sel();
        rf = request_valid && fs >= 0;
        cf = ss >= 0 && completion_ready;
        dup = 1'b0;
        for (int i = 0; i < S; i++)
            if (m_occ[i] && m_idx[i] == int'(request_index)) dup = 1'b1;
        if (completion_valid && completion_ready)
            cq.push_back(int'(completion_index));
        @(posedge clock);
        #1;
        now++;
        if (cf) m_occ[ss] = 1'b0;
        if (rf) begin
            m_occ[fs] = 1'b1;
            m_idx[fs] = int'(request_index);
            m_dat[fs] = int'(request_data);
            m_el[fs]  = now + int'(request_delay);
        end
        m_dup = rf && dup;
    endtask

    task automatic do_reset();
        request_valid = 1'b0;
        completion_ready = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic set_req(input int idx, input int dat, input int dly);
        request_valid = 1'b1;
        request_index = IW'(idx);
        request_data  = W'(dat);
        request_delay = DW'(dly);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({completion_valid, request_ready, full, empty} !== 4'b0101)
            $display("FAIL reset_flags got v/rdy/full/empty=%b want 0101",
                     {completion_valid, request_ready, full, empty});
        else n_pass++;
        n_chk++;
        if ({completion_index, completion_data} !== '0)
            $display("FAIL reset_outputs got idx=%0d data=%0h want 0/0",
                     completion_index, completion_data);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        completion_ready = 1'b1;
        set_req(2, 'hA5, 3);
        tick();
        request_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (completion_valid !== 1'b0)
                $display("FAIL single_early k=%0d got valid=%b want 0",
                         k, completion_valid);
            else n_pass++;
            if (k < 2) tick();
        end
        tick();
        n_chk++;
        if ({completion_valid, completion_index, completion_data}
            !== {1'b1, 3'd2, 8'hA5})
            $display("FAIL single_out got v=%b idx=%0d data=%0h want 1/2/a5",
                     completion_valid, completion_index, completion_data);
        else n_pass++;
        tick();
        n_chk++;
        if ({empty, completion_valid} !== 2'b10)
            $display("FAIL single_drain got empty=%b valid=%b want 1/0",
                     empty, completion_valid);
        else n_pass++;
    endtask

    task automatic test_out_of_order();
        do_reset();
        completion_ready = 1'b1;
        set_req(0, 'h10, 5);
        tick();
        set_req(1, 'h11, 1);
        tick();
        set_req(2, 'h12, 0);
        tick();
        request_valid = 1'b0;
        for (int k = 0; k < 30 && cq.size() < 3; k++) tick();
        n_chk++;
        if (cq.size() !== 3)
            $display("FAIL ooo_count got %0d want 3", cq.size());
        else n_pass++;
        n_chk++;
        if (cq.size() != 3 || cq[0] != 1 || cq[1] != 2 || cq[2] != 0)
            $display("FAIL ooo_order got %p want '{1,2,0}", cq);
        else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < S; i++) begin
            set_req(i, 'h20 + i, 15);
            tick();
        end
        set_req(4, 'h44, 0);
        n_chk++;
        if ({full, request_ready} !== 2'b10)
            $display("FAIL full_flag got full=%b rdy=%b want 1/0",
                     full, request_ready);
        else n_pass++;
        repeat (3) tick();
        n_chk++;
        if ({full, request_ready} !== 2'b10)
            $display("FAIL full_held got full=%b rdy=%b want 1/0",
                     full, request_ready);
        else n_pass++;
        for (int k = 0; k < 40 && !completion_valid; k++) tick();
        n_chk++;
        if ({completion_valid, completion_index} !== {1'b1, 3'd0})
            $display("FAIL full_first got v=%b idx=%0d want 1/0",
                     completion_valid, completion_index);
        else n_pass++;
        completion_ready = 1'b1;
        tick();
        completion_ready = 1'b0;
        n_chk++;
        if ({request_ready, full} !== 2'b10)
            $display("FAIL full_release got rdy=%b full=%b want 1/0",
                     request_ready, full);
        else n_pass++;
        tick();
        request_valid = 1'b0;
        n_chk++;
        if ({full, completion_valid, completion_index, completion_data}
            !== {2'b11, 3'd4, 8'h44})
            $display("FAIL full_refill got full=%b v=%b idx=%0d data=%0h want 1/1/4/44",
                     full, completion_valid, completion_index, completion_data);
        else n_pass++;
        completion_ready = 1'b1;
        for (int k = 0; k < 40 && !empty; k++) tick();
        n_chk++;
        if (empty !== 1'b1)
            $display("FAIL full_drain got empty=%b want 1", empty);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(6, 'h3C, 2);
        tick();
        request_valid = 1'b0;
        for (int k = 0; k < 10 && !completion_valid; k++) tick();
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if ({completion_valid, completion_index, completion_data}
                !== {1'b1, 3'd6, 8'h3C})
                $display("FAIL bp_stable k=%0d got v=%b idx=%0d data=%0h want 1/6/3c",
                         k, completion_valid, completion_index, completion_data);
            else n_pass++;
            tick();
        end
        completion_ready = 1'b1;
        tick();
        n_chk++;
        if (cq.size() != 1 || cq[0] != 6 || empty !== 1'b1)
            $display("FAIL bp_release got n=%0d empty=%b want 1 completion of 6, empty",
                     cq.size(), empty);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1, 'h31, 0);
        tick();
        set_req(2, 'h32, 4);
        tick();
        set_req(3, 'h33, 4);
        tick();
        request_valid = 1'b0;
        n_chk++;
        if (completion_valid !== 1'b1)
            $display("FAIL rstmid_pre got valid=%b want 1", completion_valid);
        else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        n_chk++;
        if ({completion_valid, request_ready, full, empty,
             completion_index, completion_data} !== {4'b0101, 11'd0})
            $display("FAIL rstmid_async got v/rdy/full/empty=%b idx=%0d data=%0h want 0101/0/0",
                     {completion_valid, request_ready, full, empty},
                     completion_index, completion_data);
        else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        model_clear();
        completion_ready = 1'b1;
        repeat (20) tick();
        n_chk++;
        if (cq.size() != 0 || empty !== 1'b1)
            $display("FAIL rstmid_post got %0d completions empty=%b want 0/1",
                     cq.size(), empty);
        else n_pass++;
    endtask

`ifdef VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN
    task automatic test_duplicate();
        do_reset();
        set_req(5, 'h55, 8);
        tick();
        n_chk++;
        if (duplicate_error !== 1'b0)
            $display("FAIL dup_first got %b want 0", duplicate_error);
        else n_pass++;
        set_req(5, 'h56, 0);
        tick();
        request_valid = 1'b0;
        n_chk++;
        if (duplicate_error !== 1'b1)
            $display("FAIL dup_pulse got %b want 1", duplicate_error);
        else n_pass++;
        tick();
        n_chk++;
        if (duplicate_error !== 1'b0)
            $display("FAIL dup_single got %b want 0", duplicate_error);
        else n_pass++;
        completion_ready = 1'b1;
        for (int k = 0; k < 30 && cq.size() < 2; k++) tick();
        n_chk++;
        if (cq.size() != 2 || cq[0] != 5 || cq[1] != 5)
            $display("FAIL dup_both got %p want '{5,5}", cq);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        int es;
        logic [IW-1:0] ei;
        logic [W-1:0] ed;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            request_valid = ($urandom_range(0, 1) == 1);
            request_index = IW'($urandom);
            request_data  = W'($urandom);
            request_delay = ($urandom_range(0, 9) == 0) ?
                            DW'(15) : DW'($urandom_range(0, 7));
            completion_ready = ($urandom_range(0, 9) < 7);
            tick();
            es = m_sel();
            ei = (es >= 0) ? IW'(m_idx[es]) : '0;
            ed = (es >= 0) ? W'(m_dat[es]) : '0;
            n_chk++;
            if (completion_valid !== (es >= 0))
                $display("FAIL rnd_valid c=%0d got %b want %b",
                         c, completion_valid, es >= 0);
            else n_pass++;
            n_chk++;
            if ({completion_index, completion_data} !== {ei, ed})
                $display("FAIL rnd_out c=%0d got idx=%0d data=%0h want %0d/%0h",
                         c, completion_index, completion_data, ei, ed);
            else n_pass++;
            n_chk++;
            if ({request_ready, full, empty}
                !== {m_free() >= 0, m_free() < 0, m_empty()})
                $display("FAIL rnd_flags c=%0d got rdy/full/empty=%b want %b",
                         c, {request_ready, full, empty},
                         {m_free() >= 0, m_free() < 0, m_empty()});
            else n_pass++;
`ifdef VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN
            n_chk++;
            if (duplicate_error !== m_dup)
                $display("FAIL rnd_dup c=%0d got %b want %b",
                         c, duplicate_error, m_dup);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_out_of_order();
        test_full();
        test_backpressure();
        test_reset_mid();
`ifdef VALID_READY_OUT_OF_ORDER_COMPLETER_DUPLICATE_CHECK_EN
        test_duplicate();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
